// File: rtl/cursor_blinker.sv
// rtl/cursor_blinker.sv - self-timed SIZE x SIZE cursor painter with optional blink phase
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   init             start request, sampled only while idle
//   in_x, in_y       cursor top-left corner (latched on init)
//   color_on/off     ON / OFF paint colours (latched on init)
//   blink_en         1 = ON then OFF phase, 0 = ON phase only (latched on init)
//   paint_ack        frame-buffer writer accepted the current pixel
//   out_x, out_y     pixel coordinate being written
//   px_data          pixel colour being written
//   paint            write request, held with stable data until paint_ack
//   busy             high whenever not idle
//   cursor_done      high for DONE_HOLD cycles at the end of a sequence
module cursor_blinker #(
  parameter int COORD_W    = 6,
  parameter int PX_W       = 8,
  parameter int SIZE       = 2,
  parameter int ON_CYCLES  = 1024,
  parameter int OFF_CYCLES = 1024,
  parameter int DONE_HOLD  = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [PX_W-1:0]    color_on,
  input  logic [PX_W-1:0]    color_off,
  input  logic               blink_en,
  input  logic               paint_ack,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [PX_W-1:0]    px_data,
  output logic               paint,
  output logic               busy,
  output logic               cursor_done
);

  localparam int IDX_W   = $clog2(SIZE) + 1;
  localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int HOLD_W  = $clog2(DONE_HOLD + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SIZE - 1);
  localparam logic [TMR_W-1:0]  ON_LOAD   = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD  = TMR_W'(OFF_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DONE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PAINT_ON  = 3'd1,
    S_WAIT_ON   = 3'd2,
    S_PAINT_OFF = 3'd3,
    S_WAIT_OFF  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    dx_q, dx_d;
  logic [IDX_W-1:0]    dy_q, dy_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [COORD_W-1:0]  bx_q, bx_d;
  logic [COORD_W-1:0]  by_q, by_d;
  logic [PX_W-1:0]     con_q, con_d;
  logic [PX_W-1:0]     coff_q, coff_d;
  logic                blink_q, blink_d;

  logic [COORD_W-1:0]  out_x_q, out_x_d;
  logic [COORD_W-1:0]  out_y_q, out_y_d;
  logic [PX_W-1:0]     px_q, px_d;
  logic                paint_q, paint_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                painting_q;
  logic                advance;
  logic                last_px;
  logic [COORD_W:0]    sum_x;
  logic [COORD_W:0]    sum_y;
  logic                painting_d;

  // State register: every register, including the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      timer_q <= '0;
      hold_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      con_q   <= '0;
      coff_q  <= '0;
      blink_q <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
      px_q    <= '0;
      paint_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      con_q   <= con_d;
      coff_q  <= coff_d;
      blink_q <= blink_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      px_q    <= px_d;
      paint_q <= paint_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A pixel index moves on when the outstanding write is acked, or at once
  // when the current pixel was clipped (paint_q low in a paint state).
  assign painting_q = (state_q == S_PAINT_ON) || (state_q == S_PAINT_OFF);
  assign advance    = painting_q && (!paint_q || paint_ack);
  assign last_px    = (dx_q == IDX_LAST) && (dy_q == IDX_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    bx_d    = bx_q;
    by_d    = by_q;
    con_d   = con_q;
    coff_d  = coff_q;
    blink_d = blink_q;

    case (state_q)
      S_IDLE: begin
        if (init) begin
          bx_d    = in_x;
          by_d    = in_y;
          con_d   = color_on;
          coff_d  = color_off;
          blink_d = blink_en;
          dx_d    = '0;
          dy_d    = '0;
          state_d = S_PAINT_ON;
        end
      end

      S_PAINT_ON, S_PAINT_OFF: begin
        if (advance) begin
          if (last_px) begin
            dx_d = '0;
            dy_d = '0;
            if (state_q == S_PAINT_ON) begin
              state_d = S_WAIT_ON;
              timer_d = ON_LOAD;
            end else begin
              state_d = S_WAIT_OFF;
              timer_d = OFF_LOAD;
            end
          end else if (dx_q == IDX_LAST) begin
            dx_d = '0;
            dy_d = dy_q + IDX_W'(1);
          end else begin
            dx_d = dx_q + IDX_W'(1);
          end
        end
      end

      S_WAIT_ON: begin
        if (timer_q == '0) begin
          if (blink_q) begin
            state_d = S_PAINT_OFF;
            dx_d    = '0;
            dy_d    = '0;
          end else begin
            state_d = S_DONE;
            hold_d  = HOLD_LOAD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      S_WAIT_OFF: begin
        if (timer_q == '0) begin
          state_d = S_DONE;
          hold_d  = HOLD_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      S_DONE: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: outputs are registered, so they are derived from the
  // next state and next pixel index. Sums are one bit wider so a pixel past
  // the screen edge is detected and skipped instead of wrapping to 0.
  assign painting_d = (state_d == S_PAINT_ON) || (state_d == S_PAINT_OFF);
  assign sum_x      = {1'b0, bx_d} + (COORD_W + 1)'(dx_d);
  assign sum_y      = {1'b0, by_d} + (COORD_W + 1)'(dy_d);

  always_comb begin
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    px_d    = px_q;
    paint_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    if (painting_d) begin
      out_x_d = sum_x[COORD_W-1:0];
      out_y_d = sum_y[COORD_W-1:0];
      px_d    = (state_d == S_PAINT_ON) ? con_d : coff_d;
      paint_d = !sum_x[COORD_W] && !sum_y[COORD_W];
    end
  end

  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign px_data     = px_q;
  assign paint       = paint_q;
  assign busy        = busy_q;
  assign cursor_done = done_q;

endmodule
